blackjack_dealer: RTL
=====================

# blackjack_dealer

Round sequencer that sits on the requesting side of the card puller's `userSelect`/`card` interface. It requests cards, captures the returned values, and keeps player and dealer totals with ace handling. It runs the deal, player and dealer turns, then reports the outcome. It also drives the puller's deck reset at the start of every round.

## Interface
Parameters:
- `DEALER_STAND`, 17, dealer stops drawing at best total ≥ this value.

Ports:
- `clk`  in  1  system clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high; aborts any round.
- `start`  in  1  one-cycle pulse; begins a round. Accepted only in IDLE or DONE.
- `hit`  in  1  one-cycle pulse; player draws. Honoured only in PLAYER.
- `stand`  in  1  one-cycle pulse; player ends turn. Wins over `hit` when both are high in the same cycle.
- `userSelect`  out  2  to the puller. 0 = no request, 1 = player draw, 2 = dealer draw. 3 is never driven.
- `card`  in  4  from the puller. 0 = no card, 1..10 = card value (1 = ace).
- `deck_reset`  out  1  one-cycle pulse on each accepted `start`; drives the puller `reset`.
- `player_total`  out  5  best player total.
- `dealer_total`  out  5  best dealer total.
- `player_turn`  out  1  high while in PLAYER.
- `result`  out  2  0 = none, 1 = player wins, 2 = dealer wins, 3 = push. Held until the next accepted `start`.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, REQ, REL, PLAYER, DEALER, SETTLE, DONE.
- Accepted `start`:
  - clears totals, ace flags, deal counter and `result`;
  - pulses `deck_reset`;
  - enters REQ with target = player.
- REQ:
  - drives `userSelect` = target (1 or 2);
  - on the first cycle with `card` ≠ 0, captures `card` into the target hand and goes to REL.
- REL:
  - drives `userSelect` = 0;
  - stays until `card` == 0, with a minimum of one cycle, so a stale value is never captured twice.
  - On exit, next state is chosen by phase:
    - Initial deal: order is P, D, P, D using a 2-bit counter; the next deal card goes back to REQ.
    - After the 4th deal card: if the player's best total is 21, go to DEALER; otherwise go to PLAYER.
    - Player draw: if busted, go to SETTLE; if best total is 21, go to DEALER; otherwise go to PLAYER.
    - Dealer draw: go to DEALER.
- PLAYER: `stand` goes to DEALER; `hit` goes to REQ with target = player.
- DEALER: if the dealer's best total < `DEALER_STAND` (see Configuration), go to REQ with target = dealer; otherwise go to SETTLE.
- SETTLE (one cycle), then DONE:
  - player busted → 2;
  - else dealer busted → 1;
  - else higher best total wins;
  - equal totals → 3.
- DONE holds all outputs until `start`.
- Arithmetic:
  - Each hand keeps a 5-bit hard sum (aces count 1) and an ace flag.
  - best = hard + 10 if the ace flag is set and hard ≤ 11; otherwise best = hard.
  - Bust means hard > 21.
  - Hard sum never exceeds 30, so there is no wrap.
- `start` outside IDLE/DONE is ignored. `hit`/`stand` outside PLAYER are ignored.
- There is no timeout. REQ waits indefinitely for a card, and `reset` is the only exit.

## Timing
- Reset values:
  - `userSelect` = 0, `deck_reset` = 0, `player_total` = 0, `dealer_total` = 0;
  - `player_turn` = 0, `result` = 0, `done` = 0;
  - state = IDLE.
- `deck_reset` is high in the cycle after `start` is sampled. `userSelect` is first asserted in the cycle after that.
- Against a puller that answers one cycle after request, each card costs 3 cycles: REQ (2 cycles) + REL (1 cycle).
- Totals update on the cycle after capture.
- `result` and `done` are valid the cycle after SETTLE.
- `reset` mid-round: all outputs return to reset values on the next edge, and `userSelect` drops to 0.

## Configuration
- `DEALER_HIT_SOFT17_EN`:
  - Defined: the dealer also draws when best total = 17 and the hand is soft (ace counted as 11).
  - Undefined: the dealer stands on every 17.

## Test plan
- Player 10,7, dealer 9,8, `stand` → no extra requests; `result` = 3; totals 17/17.
- Player A,K, dealer 10,6 → PLAYER skipped; dealer draws 5 → 21; `result` = 3 (push at 21/21).
- Player 10,6, `hit` returns 8 → bust at 24; dealer makes no draw; `result` = 2.
- Dealer A,6 (soft 17): with macro, one more dealer request; without macro, none. Player 10,9 → `result` = 1 when the dealer stands.
- Puller latency of 5 cycles and `card` held nonzero 2 cycles after `userSelect` drops → each card captured exactly once; `userSelect` = 0 for ≥ 1 cycle between requests.
- `reset` asserted while in REQ → next cycle `userSelect` = 0, totals 0, IDLE; `start` mid-round ignored (no `deck_reset` pulse).

Source files
------------

// File: rtl/blackjack_dealer.sv
// blackjack_dealer: blackjack round sequencer for a card puller; define DEALER_HIT_SOFT17_EN to make the dealer hit soft 17
module blackjack_dealer #(
  parameter int DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic [1:0] userSelect,
  input  logic [3:0] card,
  output logic       deck_reset,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic       player_turn,
  output logic [1:0] result,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, REQ, REL, PLAYER, DEALER, SETTLE, DONE} state_t;
  state_t r_state, w_next;
  logic [4:0] r_p_hard, r_d_hard, w_p_best, w_d_best;
  logic [1:0] r_cnt, r_target, r_result, w_target;
  logic r_p_ace, r_d_ace, r_dealing, r_deck_reset;
  logic w_start, w_capture, w_p_bust, w_d_bust, w_d_draw, w_rel_exit;
  assign w_p_best = (r_p_ace && r_p_hard <= 5'd11) ? r_p_hard + 5'd10 : r_p_hard;
  assign w_d_best = (r_d_ace && r_d_hard <= 5'd11) ? r_d_hard + 5'd10 : r_d_hard;
  assign w_p_bust = r_p_hard > 5'd21;
  assign w_d_bust = r_d_hard > 5'd21;
  // a start seen during the deck-reset cycle would restart an already-restarted round
  assign w_start = start && !r_deck_reset && (r_state == IDLE || r_state == DONE);
  assign w_target = r_dealing ? (r_cnt[0] ? 2'd2 : 2'd1) : r_target;
  assign w_capture = r_state == REQ && card != 4'd0;
  assign w_rel_exit = r_state == REL && card == 4'd0;
`ifdef DEALER_HIT_SOFT17_EN
  assign w_d_draw = ({27'd0, w_d_best} < DEALER_STAND) || (w_d_best == 5'd17 && r_d_ace && r_d_hard <= 5'd11);
`else
  assign w_d_draw = {27'd0, w_d_best} < DEALER_STAND;
`endif
  assign deck_reset = r_deck_reset;
  assign player_total = w_p_best;
  assign dealer_total = w_d_best;
  assign player_turn = r_state == PLAYER;
  assign result = r_result;
  assign done = r_state == DONE;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    userSelect = 2'd0;
    case (r_state)
      IDLE, DONE: w_next = r_deck_reset ? REQ : (w_start ? IDLE : r_state);
      REQ: begin
        userSelect = w_target;
        w_next = card != 4'd0 ? REL : REQ;
      end
      REL:
        if (card == 4'd0)
          w_next = r_dealing ? (r_cnt != 2'd0 ? REQ : (w_p_best == 5'd21 ? DEALER : PLAYER)) :
                   r_target == 2'd1 ? (w_p_bust ? SETTLE : (w_p_best == 5'd21 ? DEALER : PLAYER)) : DEALER;
      PLAYER: w_next = stand ? DEALER : (hit ? REQ : PLAYER);
      DEALER: w_next = w_d_draw ? REQ : SETTLE;
      SETTLE: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_hard <= 5'd0;
      r_d_hard <= 5'd0;
      r_p_ace <= 1'b0;
      r_d_ace <= 1'b0;
      r_cnt <= 2'd0;
      r_target <= 2'd1;
      r_dealing <= 1'b0;
      r_deck_reset <= 1'b0;
      r_result <= 2'd0;
    end else begin
      r_deck_reset <= w_start;
      if (w_start) begin
        r_p_hard <= 5'd0;
        r_d_hard <= 5'd0;
        r_p_ace <= 1'b0;
        r_d_ace <= 1'b0;
        r_cnt <= 2'd0;
        r_target <= 2'd1;
        r_dealing <= 1'b1;
        r_result <= 2'd0;
      end
      if (w_capture && w_target == 2'd1) begin
        r_p_hard <= r_p_hard + {1'b0, card};
        r_p_ace <= r_p_ace | (card == 4'd1);
      end
      if (w_capture && w_target == 2'd2) begin
        r_d_hard <= r_d_hard + {1'b0, card};
        r_d_ace <= r_d_ace | (card == 4'd1);
      end
      if (w_capture && r_dealing) r_cnt <= r_cnt + 2'd1;
      // the counter wraps to 0 on the 4th deal card, which ends the deal
      if (w_rel_exit && r_dealing && r_cnt == 2'd0) r_dealing <= 1'b0;
      if (r_state == DEALER) r_target <= 2'd2;
      if (r_state == SETTLE)
        r_result <= w_p_bust ? 2'd2 : w_d_bust ? 2'd1 :
                    w_p_best > w_d_best ? 2'd1 : w_p_best < w_d_best ? 2'd2 : 2'd3;
    end
  end
endmodule
